image_block_loader: RTL



---
 rtl/img_loader_pkg.sv | 23 ++
 rtl/image_block_loader_strip_bank.sv | 31 +++
 rtl/image_block_loader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/img_loader_pkg.sv
// Shared types and default geometry for the image block loader.
// Geometry defaults describe a 512x512 image cut into 4x4 blocks.
package img_loader_pkg;

  localparam int BLK          = 4;
  localparam int BLKS_PER_ROW = 512 / BLK;
  localparam int STRIPS       = 512 / BLK;

  typedef logic [7:0]   pixel_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic {
    D_IDLE,
    D_RUN
  } drain_state_e;

  // Counter width that stays legal when a counter only ever holds 0.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_block_loader_strip_bank.sv
// One strip bank: four row RAMs written one 32-bit word at a time and read
// as a full 4x4 block column with one cycle of latency.
module strip_bank
  import img_loader_pkg::*;
#(
  parameter int COLS = BLKS_PER_ROW
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [1:0]                  wrow,
  input  logic [clog2_min1(COLS)-1:0] wcol,
  input  word_t                       wdata,
  input  logic                        re,
  input  logic [clog2_min1(COLS)-1:0] rcol,
  output block_t                      rdata
);

  for (genvar r = 0; r < BLK; r++) begin : g_row
    word_t ram [COLS];
    word_t q;

    always_ff @(posedge clk) begin
      if (we && wrow == 2'(r)) ram[wcol] <= wdata;
      if (re) q <= ram[rcol];
    end

    // Row 0 lands in the top word so pixel (0,0) ends up in [127:120].
    assign rdata[(BLK-1-r)*32 +: 32] = q;
  end

endmodule

// File: rtl/image_block_loader.sv
// Raster-to-block loader: buffers 4-row strips in two banks and writes each
// 4x4 block as one 128-bit word into the block image memory.
module image_block_loader
  import img_loader_pkg::*;
#(
  parameter int IMG_W  = BLKS_PER_ROW * BLK,
  parameter int IMG_H  = STRIPS * BLK,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  output logic              frame_done,
  output logic              busy
);

  localparam int N_COLS   = IMG_W / BLK;
  localparam int N_STRIPS = IMG_H / BLK;
  localparam int COL_W    = clog2_min1(N_COLS);
  localparam int STRIP_W  = clog2_min1(N_STRIPS);
  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(N_COLS - 1);
  localparam logic [STRIP_W-1:0] LAST_STRIP = STRIP_W'(N_STRIPS - 1);

  logic [COL_W-1:0] wcol;
  logic [1:0]       wrow;
  logic             wbank;
  logic [1:0]       full;
  logic [1:0]       full_set;
  logic [1:0]       full_clr;
  logic             accept;
  logic             strip_in_done;

  drain_state_e       state;
  drain_state_e       state_nx;
  logic               rbank;
  logic [COL_W-1:0]   bcol;
  logic [STRIP_W-1:0] strip;
  logic               rd_en;
  logic               strip_done;

  block_t bank_q [2];

  logic              vld_p0;
  logic              last_p0;
  logic              rbank_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              last_p1;
  logic              ingest_pending;

  assign s_ready       = !rst && !full[wbank];
  assign accept        = s_valid && s_ready;
  assign strip_in_done = accept && wcol == LAST_COL && wrow == 2'd3;

  always_ff @(posedge clk) begin
    if (rst) begin
      wcol  <= '0;
      wrow  <= '0;
      wbank <= 1'b0;
    end else if (accept) begin
      if (wcol == LAST_COL) begin
        wcol <= '0;
        wrow <= wrow + 2'd1;
        if (wrow == 2'd3) wbank <= ~wbank;
      end else begin
        wcol <= wcol + COL_W'(1);
      end
    end
  end

  // Set and clear target different banks, so both take effect in one cycle.
  assign full_set = strip_in_done ? (2'b01 << wbank) : 2'b00;
  assign full_clr = strip_done ? (2'b01 << rbank) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) full <= '0;
    else     full <= (full & ~full_clr) | full_set;
  end

  strip_bank #(.COLS(N_COLS)) u_bank0 (
    .clk   (clk),
    .we    (accept && !wbank),
    .wrow  (wrow),
    .wcol  (wcol),
    .wdata (s_data),
    .re    (rd_en && !rbank),
    .rcol  (bcol),
    .rdata (bank_q[0])
  );

  strip_bank #(.COLS(N_COLS)) u_bank1 (
    .clk   (clk),
    .we    (accept && wbank),
    .wrow  (wrow),
    .wcol  (wcol),
    .wdata (s_data),
    .re    (rd_en && rbank),
    .rcol  (bcol),
    .rdata (bank_q[1])
  );

  // The first column is read in the cycle the bank is seen full.
  always_comb begin
    state_nx   = state;
    rd_en      = 1'b0;
    strip_done = 1'b0;
    unique case (state)
      D_IDLE: begin
        if (full[rbank]) begin
          rd_en = 1'b1;
          if (bcol == LAST_COL) begin
            strip_done = 1'b1;
            state_nx   = full[~rbank] ? D_RUN : D_IDLE;
          end else begin
            state_nx = D_RUN;
          end
        end
      end
      D_RUN: begin
        rd_en = 1'b1;
        if (bcol == LAST_COL) begin
          strip_done = 1'b1;
          state_nx   = full[~rbank] ? D_RUN : D_IDLE;
        end
      end
      default: state_nx = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= D_IDLE;
      rbank <= 1'b0;
      bcol  <= '0;
      strip <= '0;
    end else begin
      state <= state_nx;
      if (rd_en) begin
        if (strip_done) begin
          bcol  <= '0;
          rbank <= ~rbank;
          strip <= (strip == LAST_STRIP) ? '0 : strip + STRIP_W'(1);
        end else begin
          bcol <= bcol + COL_W'(1);
        end
      end
    end
  end

  // Stage p0: bank read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= rd_en;
      last_p0 <= strip_done && strip == LAST_STRIP;
    end
  end

  always_ff @(posedge clk) begin
    rbank_p0 <= rbank;
    addr_p0  <= ADDR_W'(ADDR_W'(strip) * ADDR_W'(N_COLS) + ADDR_W'(bcol));
  end

  // Stage p1: registered memory write and frame completion
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      last_p1    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mem_we     <= vld_p0;
      last_p1    <= last_p0;
      frame_done <= last_p1;
      if (vld_p0) begin
        mem_addr  <= addr_p0;
        mem_wdata <= rbank_p0 ? bank_q[1] : bank_q[0];
      end
    end
  end

  // Words of the next frame may already be buffered when this one completes.
  assign ingest_pending = (|full) || wcol != '0 || wrow != 2'd0;

  always_ff @(posedge clk) begin
    if (rst)                             busy <= 1'b0;
    else if (accept)                     busy <= 1'b1;
    else if (last_p1 && !ingest_pending) busy <= 1'b0;
  end

endmodule
